// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode definitions.
//   - Opcode constants for the instruction classes the decode stage knows about.
//   - decoded_t: the raw field bundle extracted from one 32-bit instruction word.
//   - decode_instr(): pure field extraction plus load detection.
// Register-index and datapath widths are module parameters, so this bundle
// keeps the architectural 5-bit register fields and 16/26-bit immediates;
// the decode stage resizes and extends them.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        mem_read;
  } decoded_t;

  // Split an instruction word into its fields; target overlaps rs/rt/rd/shamt/funct.
  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t d;
    d.opcode   = instr[31:26];
    d.rs       = instr[25:21];
    d.rt       = instr[20:16];
    d.rd       = instr[15:11];
    d.funct    = instr[5:0];
    d.imm      = instr[15:0];
    d.target   = instr[25:0];
    d.mem_read = (instr[31:26] == OP_LW);
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: architectural register file, 2 combinational read ports and
// 1 synchronous write port with write-through bypass.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every entry
//   wr_en      write enable
//   wr_addr    write index
//   wr_data    write value
//   rd_addr_a  read index, port A       rd_data_a  read value, port A
//   rd_addr_b  read index, port B       rd_data_b  read value, port B
// With ZERO_REG != 0, entry 0 is never written and always reads 0, and the
// bypass does not apply to index 0.
module reg_file
  import mips_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  REG_COUNT = 32,
  parameter int  ZERO_REG  = 1,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RA_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [RA_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_r [REG_COUNT];
  logic              write_ok_s;

  // Suppress writes to the hard-wired zero register.
  always_comb begin
    if (ZERO_EN && (wr_addr == {RA_W{1'b0}})) begin
      write_ok_s = 1'b0;
    end else begin
      write_ok_s = wr_en;
    end
  end

  // Register storage: asynchronous clear, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (write_ok_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read port A: zero register first, then same-cycle write bypass, then storage.
  always_comb begin
    if (ZERO_EN && (rd_addr_a == {RA_W{1'b0}})) begin
      rd_data_a = {DATA_W{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    if (ZERO_EN && (rd_addr_b == {RA_W{1'b0}})) begin
      rd_data_b = {DATA_W{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction decode pipeline stage.
// Accepts an instruction/pc pair from fetch with a valid/ready handshake,
// reads both source operands from the register file (with writeback bypass),
// computes the sign-extended immediate and the branch/jump targets, and
// presents everything one cycle later in a registered output bundle.
// A load in the output stage whose rt is needed by the incoming instruction
// forces a one-cycle bubble (hazardStall).
// Ports:
//   clk, resetN                 clock, asynchronous active-low reset
//   inValid / inReady           fetch handshake
//   instr, pc                   instruction word and its address
//   wbEn, wbReg, wbData         register-file writeback
//   flush                       kill held and incoming instruction
//   outValid / outReady         execute handshake
//   opcode, funct               instruction fields
//   regRs, regRt, regRd         register indices
//   regOut1, regOut2            operand values for rs and rt
//   immValue                    sign-extended 16-bit immediate
//   branchDest, jumpDest        control-flow targets (modulo 2^DATA_W)
//   memRead                     instruction is a load word
//   hazardStall                 load-use bubble inserted this cycle
module decode_stage
  import mips_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  REG_COUNT = 32,
  parameter int  ZERO_REG  = 1,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic              wbEn,
  input  logic [RA_W-1:0]   wbReg,
  input  logic [DATA_W-1:0] wbData,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [RA_W-1:0]   regRs,
  output logic [RA_W-1:0]   regRt,
  output logic [RA_W-1:0]   regRd,
  output logic [DATA_W-1:0] regOut1,
  output logic [DATA_W-1:0] regOut2,
  output logic [DATA_W-1:0] immValue,
  output logic [DATA_W-1:0] branchDest,
  output logic [DATA_W-1:0] jumpDest,
  output logic              memRead,
  output logic              hazardStall
);

  localparam logic [DATA_W-1:0] PC_STEP = {{(DATA_W-3){1'b0}}, 3'b100};

  decoded_t          dec_s;
  logic [RA_W-1:0]   rs_idx_s;
  logic [RA_W-1:0]   rt_idx_s;
  logic [RA_W-1:0]   rd_idx_s;
  logic [DATA_W-1:0] rs_val_s;
  logic [DATA_W-1:0] rt_val_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [DATA_W-1:0] pc_plus4_s;
  logic [DATA_W-1:0] branch_s;
  logic [DATA_W-1:0] jump_s;
  logic              advance_s;
  logic              hazard_s;
  logic              ready_s;
  logic              accept_s;

  assign dec_s = decode_instr(instr);

  // Register indices sized to the configured register count.
  assign rs_idx_s = RA_W'(dec_s.rs);
  assign rt_idx_s = RA_W'(dec_s.rt);
  assign rd_idx_s = RA_W'(dec_s.rd);

  // Target arithmetic; all sums wrap naturally at DATA_W bits.
  assign imm_ext_s  = {{(DATA_W-16){dec_s.imm[15]}}, dec_s.imm};
  assign pc_plus4_s = pc + PC_STEP;
  assign branch_s   = pc_plus4_s + (imm_ext_s << 2'd2);
  assign jump_s     = {pc_plus4_s[DATA_W-1:28], dec_s.target, 2'b00};

  // Handshake and load-use hazard. The hazard looks at the registered bundle
  // (the load now heading to execute) against the incoming source fields.
  always_comb begin
    advance_s = outReady | ~outValid;
    if (outValid && memRead && (regRt != {RA_W{1'b0}}) && inValid &&
        ((rs_idx_s == regRt) || (rt_idx_s == regRt))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
    ready_s  = advance_s & ~hazard_s & ~flush;
    accept_s = inValid & ready_s;
  end

  assign inReady     = ready_s;
  assign hazardStall = hazard_s;

  reg_file #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT),
    .ZERO_REG (ZERO_REG)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (resetN),
    .wr_en    (wbEn),
    .wr_addr  (wbReg),
    .wr_data  (wbData),
    .rd_addr_a(rs_idx_s),
    .rd_data_a(rs_val_s),
    .rd_addr_b(rt_idx_s),
    .rd_data_b(rt_val_s)
  );

  // Output bundle: flush drops valid; on advance either capture the accepted
  // instruction or present a bubble; otherwise everything holds.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outValid   <= 1'b0;
      opcode     <= 6'h00;
      funct      <= 6'h00;
      regRs      <= {RA_W{1'b0}};
      regRt      <= {RA_W{1'b0}};
      regRd      <= {RA_W{1'b0}};
      regOut1    <= {DATA_W{1'b0}};
      regOut2    <= {DATA_W{1'b0}};
      immValue   <= {DATA_W{1'b0}};
      branchDest <= {DATA_W{1'b0}};
      jumpDest   <= {DATA_W{1'b0}};
      memRead    <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (advance_s) begin
      outValid <= accept_s;
      if (accept_s) begin
        opcode     <= dec_s.opcode;
        funct      <= dec_s.funct;
        regRs      <= rs_idx_s;
        regRt      <= rt_idx_s;
        regRd      <= rd_idx_s;
        regOut1    <= rs_val_s;
        regOut2    <= rt_val_s;
        immValue   <= imm_ext_s;
        branchDest <= branch_s;
        jumpDest   <= jump_s;
        memRead    <= dec_s.mem_read;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic for
// decode_stage, checked against a behavioural model of the stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_ready;

  logic        inReady;
  logic        outValid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  regRs;
  logic [4:0]  regRt;
  logic [4:0]  regRd;
  logic [31:0] regOut1;
  logic [31:0] regOut2;
  logic [31:0] immValue;
  logic [31:0] branchDest;
  logic [31:0] jumpDest;
  logic        memRead;
  logic        hazardStall;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [5:0]  m_op;
  logic [5:0]  m_funct;
  logic [4:0]  m_rs;
  logic [4:0]  m_rt;
  logic [4:0]  m_rd;
  logic [31:0] m_r1;
  logic [31:0] m_r2;
  logic [31:0] m_imm;
  logic [31:0] m_br;
  logic [31:0] m_jd;
  logic        m_mr;

  always #5 clk = ~clk;

  decode_stage #(
    .DATA_W   (32),
    .REG_COUNT(32),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .resetN     (rst_n),
    .inValid    (in_valid),
    .inReady    (inReady),
    .instr      (in_instr),
    .pc         (in_pc),
    .wbEn       (wb_en),
    .wbReg      (wb_reg),
    .wbData     (wb_data),
    .flush      (flush),
    .outValid   (outValid),
    .outReady   (out_ready),
    .opcode     (opcode),
    .funct      (funct),
    .regRs      (regRs),
    .regRt      (regRt),
    .regRd      (regRd),
    .regOut1    (regOut1),
    .regOut2    (regOut2),
    .immValue   (immValue),
    .branchDest (branchDest),
    .jumpDest   (jumpDest),
    .memRead    (memRead),
    .hazardStall(hazardStall)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  // Architectural read: r0 is zero, a same-cycle writeback wins, else stored value.
  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && (wb_reg == r)) return wb_data;
    return m_regs[r];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
    m_op = 6'd0; m_funct = 6'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    m_r1 = 32'd0; m_r2 = 32'd0; m_imm = 32'd0; m_br = 32'd0; m_jd = 32'd0;
    m_mr = 1'b0;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    wb_en     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  // One clock: check handshake outputs mid-cycle, advance the model at the
  // edge, then compare the registered bundle.
  task automatic step();
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hz;
    logic        adv;
    logic        rdy;
    logic        acc;
    logic [31:0] immv;
    @(negedge clk);
    rs  = in_instr[25:21];
    rt  = in_instr[20:16];
    hz  = m_valid && m_mr && (m_rt != 5'd0) && in_valid && ((rs == m_rt) || (rt == m_rt));
    adv = out_ready || !m_valid;
    rdy = adv && !hz && !flush;
    acc = in_valid && rdy;
    check_eq("hazardStall", 64'(hazardStall), 64'(hz));
    check_eq("inReady", 64'(inReady), 64'(rdy));
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 1'b0;
    end else if (adv) begin
      m_valid = acc;
      if (acc) begin
        m_op    = in_instr[31:26];
        m_funct = in_instr[5:0];
        m_rs    = rs;
        m_rt    = rt;
        m_rd    = in_instr[15:11];
        m_r1    = model_read(rs);
        m_r2    = model_read(rt);
        immv    = in_instr[15] ? (32'hFFFF_0000 | {16'h0000, in_instr[15:0]})
                               : {16'h0000, in_instr[15:0]};
        m_imm   = immv;
        m_br    = in_pc + 32'd4 + immv * 32'd4;
        m_jd    = ((in_pc + 32'd4) & 32'hF000_0000) | ({6'd0, in_instr[25:0]} * 32'd4);
        m_mr    = (in_instr[31:26] == 6'h23);
      end
    end
    if (wb_en && (wb_reg != 5'd0)) m_regs[wb_reg] = wb_data;
    check_eq("outValid", 64'(outValid), 64'(m_valid));
    if (m_valid) begin
      check_eq("opcode", 64'(opcode), 64'(m_op));
      check_eq("funct", 64'(funct), 64'(m_funct));
      check_eq("regRs", 64'(regRs), 64'(m_rs));
      check_eq("regRt", 64'(regRt), 64'(m_rt));
      check_eq("regRd", 64'(regRd), 64'(m_rd));
      check_eq("regOut1", 64'(regOut1), 64'(m_r1));
      check_eq("regOut2", 64'(regOut2), 64'(m_r2));
      check_eq("immValue", 64'(immValue), 64'(m_imm));
      check_eq("branchDest", 64'(branchDest), 64'(m_br));
      check_eq("jumpDest", 64'(jumpDest), 64'(m_jd));
      check_eq("memRead", 64'(memRead), 64'(m_mr));
    end
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset(input string tag);
    idle();
    rst_n = 1'b0;
    #2;
    check_eq({tag, "_valid"}, 64'(outValid), 64'd0);
    check_eq({tag, "_hazard"}, 64'(hazardStall), 64'd0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_instr = 32'd0;
    in_pc    = 32'd0;
    wb_reg   = 5'd0;
    wb_data  = 32'd0;
    idle();
    pulse_reset("por");

    // Writeback then read through a register-register instruction
    idle(); wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h0000_1234; step();
    idle(); in_valid = 1'b1; in_pc = 32'h0000_0100;
    in_instr = enc_r(5'd5, 5'd0, 5'd3, 6'h21); step();
    check_eq("addu_valid", 64'(outValid), 64'd1);
    check_eq("addu_rs_val", 64'(regOut1), 64'h1234);
    check_eq("addu_rt_val", 64'(regOut2), 64'h0);

    // Writes to r0 are ignored
    idle(); wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'h0000_FFFF; step();
    idle(); in_valid = 1'b1; in_instr = enc_r(5'd0, 5'd5, 5'd4, 6'h21); step();
    check_eq("r0_read", 64'(regOut1), 64'h0);
    check_eq("r5_read", 64'(regOut2), 64'h1234);

    // Same-cycle writeback captured by the accepted bundle
    idle(); wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h0000_CAFE; in_valid = 1'b1;
    in_instr = enc_r(5'd7, 5'd5, 5'd6, 6'h21); step();
    check_eq("wb_bypass", 64'(regOut1), 64'hCAFE);

    // Branch and jump targets
    idle(); in_valid = 1'b1; in_pc = 32'h0040_0000;
    in_instr = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF); step();
    check_eq("beq_dest", 64'(branchDest), 64'h0040_0000);
    check_eq("beq_imm", 64'(immValue), 64'hFFFF_FFFF);
    idle(); in_valid = 1'b1; in_pc = 32'h0040_0000; in_instr = enc_j(26'h010_0000); step();
    check_eq("j_dest", 64'(jumpDest), 64'h0040_0000);
    idle(); in_valid = 1'b1; in_pc = 32'hFFFF_FFFC;
    in_instr = enc_i(6'h04, 5'd1, 5'd2, 16'h0001); step();
    check_eq("beq_wrap", 64'(branchDest), 64'h4);

    // Load-use bubble
    idle(); in_valid = 1'b1; in_instr = enc_i(6'h23, 5'd1, 5'd8, 16'h0000); step();
    idle(); in_valid = 1'b1; in_instr = enc_r(5'd8, 5'd2, 5'd9, 6'h20);
    #1;
    check_eq("lu_stall", 64'(hazardStall), 64'd1);
    check_eq("lu_ready", 64'(inReady), 64'd0);
    step();
    check_eq("lu_bubble", 64'(outValid), 64'd0);
    #1;
    check_eq("lu_stall_clear", 64'(hazardStall), 64'd0);
    step();
    check_eq("lu_add_valid", 64'(outValid), 64'd1);
    check_eq("lu_add_rd", 64'(regRd), 64'd9);

    // Back-pressure hold then flush
    idle(); in_valid = 1'b1; in_instr = enc_r(5'd1, 5'd2, 5'd3, 6'h21); step();
    idle(); in_valid = 1'b1; out_ready = 1'b0; in_instr = enc_r(5'd4, 5'd5, 5'd6, 6'h23);
    repeat (3) step();
    check_eq("hold_rd", 64'(regRd), 64'd3);
    check_eq("hold_rs", 64'(regRs), 64'd1);
    flush = 1'b1; step();
    check_eq("flush_valid", 64'(outValid), 64'd0);

    // Reset in mid-stream discards the bundle and clears the register file
    idle(); in_valid = 1'b1; in_instr = enc_r(5'd5, 5'd7, 5'd2, 6'h21); step();
    check_eq("pre_rst_r5", 64'(regOut1), 64'h1234);
    pulse_reset("mid_rst");
    idle(); in_valid = 1'b1; in_instr = enc_r(5'd5, 5'd7, 5'd2, 6'h21); step();
    check_eq("post_rst_valid", 64'(outValid), 64'd1);
    check_eq("post_rst_r5", 64'(regOut1), 64'h0);
    check_eq("post_rst_r7", 64'(regOut2), 64'h0);

    // Randomized traffic; small register range to provoke hazards and bypasses
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_reg    = 5'($urandom_range(0, 7));
      wb_data   = $urandom();
      in_pc     = $urandom();
      case ($urandom_range(0, 4))
        0: in_instr = enc_i(6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            16'($urandom()));
        1: in_instr = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 6'($urandom()));
        2: in_instr = enc_i(6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            16'($urandom()));
        3: in_instr = enc_j(26'($urandom()));
        default: in_instr = $urandom();
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
